// File: rtl/r200memarb_pkg.sv
// Shared encodings for the r200 unified-memory arbiter: FSM states and access owner.
package r200memarb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  localparam int unsigned STARVE_W = 3;

endpackage

// File: rtl/r200arb_pick.sv
// Combinational winner select between fetch and data requesters; one-hot grant.
module r200arb_pick (
  input  logic       arb_en_i,
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  logic       starve_i,
  output logic [1:0] gnt_o      // [0] = IF, [1] = D
);

  always_comb begin
    gnt_o = 2'b00;
    if (arb_en_i) begin
      // Data wins unless fetch is alone or has been starved long enough.
      if (if_req_i && (starve_i || !d_req_i)) begin
        gnt_o = 2'b01;
      end else if (d_req_i) begin
        gnt_o = 2'b10;
      end
    end
  end

endmodule

// File: rtl/r200memarb.sv
// Fetch/data arbiter for one single-ported fixed-latency memory, IDLE/WAIT/RESP FSM.
// Optional fetch anti-starvation counter enabled by defining R200_ARB_FAIRNESS_EN.
module r200memarb
  import r200memarb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  // Handshake: a requester holds req and its payload until it sees gnt high in
  // a cycle; the response is a single-cycle rvalid MEM_LAT+1 cycles after gnt.

  arb_state_e  state_q, state_d;
  arb_owner_e  owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        kill_q, kill_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        arb_en;
  logic        starve;
  logic [1:0]  gnt;

  // Holding rst out of the arbiter keeps grants and strobes low during reset.
  assign arb_en = rst && ((state_q == ARB_IDLE) || (state_q == ARB_RESP));

  r200arb_pick u_pick (
    .arb_en_i (arb_en),
    .if_req_i (if_req),
    .d_req_i  (d_req),
    .starve_i (starve),
    .gnt_o    (gnt)
  );

`ifdef R200_ARB_FAIRNESS_EN
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign starve = if_req && (starve_q == STARVE_W'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (gnt[0]) begin
      starve_d = '0;
    end else if (gnt[1] && if_req && (starve_q != '1)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    kill_d     = kill_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ARB_IDLE, ARB_RESP: begin
        if (|gnt) begin
          state_d = ARB_WAIT;
          owner_d = gnt[0] ? OWN_IF : OWN_D;
          cnt_d   = CW'(MEM_LAT - 1);
          we_d    = gnt[1] & d_we;
          kill_d  = gnt[0] & if_kill;
        end else begin
          state_d = ARB_IDLE;
          owner_d = OWN_NONE;
          we_d    = 1'b0;
          kill_d  = 1'b0;
        end
      end
      ARB_WAIT: begin
        kill_d = kill_q | ((owner_q == OWN_IF) & if_kill);
        if (cnt_q == '0) begin
          state_d = ARB_RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d = m_rdata;
          end else if (!we_q) begin
            d_rdata_d = m_rdata;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_NONE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      kill_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      kill_q     <= kill_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_gnt  = gnt[0];
  assign d_gnt   = gnt[1];
  assign m_en    = |gnt;
  assign m_we    = gnt[1] & d_we;
  assign m_addr  = gnt[1] ? d_addr : (gnt[0] ? if_addr : 32'h0);
  assign m_wdata = gnt[1] ? d_wdata : 32'h0;
  assign busy    = (state_q != ARB_IDLE);

  // A kill arriving in the response cycle itself still suppresses the pulse.
  assign if_rvalid = (state_q == ARB_RESP) && (owner_q == OWN_IF) && !kill_q && !if_kill;
  assign d_rvalid  = (state_q == ARB_RESP) && (owner_q == OWN_D);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_r200memarb.sv
// Directed bench for r200memarb: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_r200memarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, m_en1, m_we1, busy1;
  logic [31:0] if_rdata1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, m_en3, m_we3, busy3;
  logic [31:0] if_rdata3, d_rdata3, m_addr3, m_wdata3, m_rdata3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  r200memarb #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(m_rdata1), .busy(busy1)
  );

  r200memarb #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3),
    .m_rdata(m_rdata3), .busy(busy3)
  );

  // Memory models: contents preloaded with a known pattern, fixed read latency.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA500_0000 | a;
  endfunction

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] rd3_p0, rd3_p1;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = pat(32'(i));
      mem3[i] = pat(32'(i));
    end
  end

  always @(posedge clk) begin
    if (m_en1 && m_we1) mem1[m_addr1[9:0]] <= m_wdata1;
    m_rdata1 <= mem1[m_addr1[9:0]];
    if (m_en3 && m_we3) mem3[m_addr3[9:0]] <= m_wdata3;
    rd3_p0   <= mem3[m_addr3[9:0]];
    rd3_p1   <= rd3_p0;
    m_rdata3 <= rd3_p1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  int n_if_gnt, n_d_gnt, n_rv, lat;
  logic [31:0] got_data;

  initial begin
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h40; if_kill = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h0;
    // Reset with requests pending: no grants, everything zero.
    mid(); mid();
    chk("rst_if_gnt", {31'b0, if_gnt1}, 32'd0);
    chk("rst_d_gnt", {31'b0, d_gnt1}, 32'd0);
    chk("rst_m_en", {31'b0, m_en1}, 32'd0);
    chk("rst_m_addr", m_addr1, 32'h0);
    chk("rst_busy", {31'b0, busy1}, 32'd0);
    chk("rst_if_rdata", if_rdata1, 32'h0);
    chk("rst_d_rdata", d_rdata1, 32'h0);
    cyc(); if_req = 1'b0; d_req = 1'b0;
    cyc(); rst = 1'b1;
    cyc();

    // Lone fetch, MEM_LAT=1.
    cyc(); if_req = 1'b1; if_addr = 32'h40;
    mid();
    chk("f1_if_gnt", {31'b0, if_gnt1}, 32'd1);
    chk("f1_m_en", {31'b0, m_en1}, 32'd1);
    chk("f1_m_we", {31'b0, m_we1}, 32'd0);
    chk("f1_m_addr", m_addr1, 32'h40);
    cyc(); if_req = 1'b0;
    mid();
    chk("f1_busy_wait", {31'b0, busy1}, 32'd1);
    chk("f1_no_early_rv", {31'b0, if_rvalid1}, 32'd0);
    cyc(); mid();
    chk("f1_if_rvalid", {31'b0, if_rvalid1}, 32'd1);
    chk("f1_if_rdata", if_rdata1, pat(32'h40));
    chk("f1_busy_resp", {31'b0, busy1}, 32'd1);
    cyc(); mid();
    chk("f1_idle", {31'b0, busy1}, 32'd0);
    chk("f1_rv_one_shot", {31'b0, if_rvalid1}, 32'd0);

    // Simultaneous fetch and load: data first, fetch granted in load's RESP.
    cyc(); if_req = 1'b1; if_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    mid();
    chk("sim_d_gnt", {31'b0, d_gnt1}, 32'd1);
    chk("sim_if_lose", {31'b0, if_gnt1}, 32'd0);
    chk("sim_m_addr_d", m_addr1, 32'h100);
    cyc(); d_req = 1'b0;
    mid();
    chk("sim_no_gnt_wait", {31'b0, if_gnt1}, 32'd0);
    cyc(); mid();
    chk("sim_d_rvalid", {31'b0, d_rvalid1}, 32'd1);
    chk("sim_d_rdata", d_rdata1, pat(32'h100));
    chk("sim_if_gnt_resp", {31'b0, if_gnt1}, 32'd1);
    chk("sim_m_addr_if", m_addr1, 32'h44);
    cyc(); if_req = 1'b0;
    cyc(); mid();
    chk("sim_if_rvalid", {31'b0, if_rvalid1}, 32'd1);
    chk("sim_if_rdata", if_rdata1, pat(32'h44));
    cyc();

    // Store then load at the same address.
    cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    mid();
    chk("st_d_gnt", {31'b0, d_gnt1}, 32'd1);
    chk("st_m_we", {31'b0, m_we1}, 32'd1);
    chk("st_m_wdata", m_wdata1, 32'hDEADBEEF);
    cyc(); d_req = 1'b0;
    cyc(); mid();
    chk("st_ack", {31'b0, d_rvalid1}, 32'd1);
    chk("st_rdata_hold", d_rdata1, pat(32'h100));
    cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    mid();
    chk("ld_d_gnt", {31'b0, d_gnt1}, 32'd1);
    chk("ld_m_we", {31'b0, m_we1}, 32'd0);
    cyc(); d_req = 1'b0;
    cyc(); mid();
    chk("ld_d_rvalid", {31'b0, d_rvalid1}, 32'd1);
    chk("ld_d_rdata", d_rdata1, 32'hDEADBEEF);
    cyc();

    // Kill one cycle after the grant.
    cyc(); if_req = 1'b1; if_addr = 32'h48;
    mid();
    chk("k1_if_gnt", {31'b0, if_gnt1}, 32'd1);
    cyc(); if_req = 1'b0; if_kill = 1'b1;
    cyc(); if_kill = 1'b0;
    mid();
    chk("k1_rv_killed", {31'b0, if_rvalid1}, 32'd0);
    chk("k1_busy_resp", {31'b0, busy1}, 32'd1);
    // Kill coincident with the grant.
    cyc(); if_req = 1'b1; if_addr = 32'h50; if_kill = 1'b1;
    mid();
    chk("k2_if_gnt", {31'b0, if_gnt1}, 32'd1);
    cyc(); if_req = 1'b0; if_kill = 1'b0;
    cyc(); mid();
    chk("k2_rv_killed", {31'b0, if_rvalid1}, 32'd0);
    // Following fetch is unaffected.
    cyc(); if_req = 1'b1; if_addr = 32'h4C;
    mid();
    chk("k3_if_gnt", {31'b0, if_gnt1}, 32'd1);
    cyc(); if_req = 1'b0;
    cyc(); mid();
    chk("k3_if_rvalid", {31'b0, if_rvalid1}, 32'd1);
    chk("k3_if_rdata", if_rdata1, pat(32'h4C));
    cyc();

    // Both requesters held over ten arbitration slots.
    n_if_gnt = 0; n_d_gnt = 0;
    cyc(); if_req = 1'b1; if_addr = 32'h60; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (if_gnt1) n_if_gnt++;
      if (d_gnt1) n_d_gnt++;
      if (i < 19) cyc();
    end
    cyc(); if_req = 1'b0; d_req = 1'b0;
`ifdef R200_ARB_FAIRNESS_EN
    chk("fair_if_gnts", 32'(n_if_gnt), 32'd2);
    chk("fair_d_gnts", 32'(n_d_gnt), 32'd8);
`else
    chk("strict_if_gnts", 32'(n_if_gnt), 32'd0);
    chk("strict_d_gnts", 32'(n_d_gnt), 32'd10);
`endif
    cyc(); cyc(); cyc();

    // Async reset in the middle of a MEM_LAT=3 access.
    rst = 1'b0;
    cyc(); rst = 1'b1;
    cyc(); if_req = 1'b1; if_addr = 32'h40;
    mid();
    chk("r3_if_gnt", {31'b0, if_gnt3}, 32'd1);
    cyc(); if_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("r3_busy_async", {31'b0, busy3}, 32'd0);
    chk("r3_m_en_async", {31'b0, m_en3}, 32'd0);
    chk("r3_if_rdata_async", if_rdata3, 32'h0);
    cyc(); rst = 1'b1;
    n_rv = 0;
    for (int i = 0; i < 6; i++) begin
      mid();
      if (if_rvalid3 || d_rvalid3) n_rv++;
      cyc();
    end
    chk("r3_no_rvalid", 32'(n_rv), 32'd0);
    if_req = 1'b1; if_addr = 32'h40;
    mid();
    chk("r3b_if_gnt", {31'b0, if_gnt3}, 32'd1);
    lat = 0; got_data = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      cyc(); if_req = 1'b0;
      mid();
      if (if_rvalid3 && lat == 0) begin
        lat = k;
        got_data = if_rdata3;
      end
    end
    chk("r3b_latency", 32'(lat), 32'd4);
    chk("r3b_if_rdata", got_data, pat(32'h40));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
